// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding, default widths and width check for the MAC job controller
package mac_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_DW    = 3;
    localparam int DEF_ACC_W = 6;
    localparam int DEF_LEN_W = 4;

    // The accumulator must at least hold one full-width product.
    function automatic bit acc_w_ok(input int dw, input int acc_w);
        return acc_w >= 2 * dw;
    endfunction

endpackage

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - product register feeding a wrapping accumulator with sticky carry flag
module mac_pipe
    import mac_ctrl_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             prod_vld
);

    localparam int PW = 2 * DW;
    localparam int SW = ACC_W + 1;

    if (!acc_w_ok(DW, ACC_W)) begin : g_bad_width
        $error("mac_pipe: ACC_W must be >= 2*DW");
    end

    logic [PW-1:0]    r_prod;
    logic             r_prod_vld;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [SW-1:0]    w_sum;

    // One extra bit captures the carry out of the accumulator MSB.
    assign w_sum = {1'b0, r_acc} + SW'(r_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_prod_vld <= en;
            if (en) begin
                r_prod <= PW'(a) * PW'(b);
            end
            if (clr) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_prod_vld) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
            end
        end
    end

    assign acc      = r_acc;
    assign ovf      = r_ovf;
    assign prod_vld = r_prod_vld;

endmodule

// File: rtl/mac_job_ctrl.sv
// rtl/mac_job_ctrl.sv - job sequencer: counts operand pairs, drains the MAC pipe, presents one result per job
module mac_job_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_z,
    output logic             out_ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_count;
    logic             w_hs;
    logic             w_clr;
    logic [ACC_W-1:0] w_acc;
    logic             w_ovf;
    logic             w_prod_vld;

    assign w_hs  = in_valid && (r_state == S_ACC);
    assign w_clr = start && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) begin
                r_count <= len;
            end else if (w_hs) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (len != '0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (w_hs && (r_count == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            // The last product is absorbed on the edge that leaves DRAIN.
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    mac_pipe #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .en       (w_hs),
        .a        (in_a),
        .b        (in_b),
        .acc      (w_acc),
        .ovf      (w_ovf),
        .prod_vld (w_prod_vld)
    );

    // Result stays in the accumulator after DONE; consumers qualify with out_valid.
    assign out_z   = w_acc;
    assign out_ovf = w_ovf;

endmodule

// File: tb/tb_mac_job_ctrl.sv
// tb/tb_mac_job_ctrl.sv - self-checking bench for mac_job_ctrl
module tb_mac_job_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_z;
    logic       out_ovf;

    int total = 0;
    int bad   = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];

    typedef struct packed {
        int             n;
        int             gap;
        int             hold;
        logic [5:0][2:0] va;
        logic [5:0][2:0] vb;
        logic [5:0]     z;
        logic           ovf;
    } vec_t;

    vec_t vecs[4];

    mac_job_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int n, input int gap, input int hold,
                           input logic [5:0] ez, input logic eovf, input string tag);
        start = 1'b1;
        len   = n[3:0];
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_a     = 3'($urandom);
                    in_b     = 3'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_a     = qa[i];
            in_b     = qb[i];
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        if (n > 0) begin
            chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
            step();
        end
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_z"}, 32'(out_z), 32'(ez));
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'(eovf));
        out_ready = 1'b0;
        len       = 4'd5;
        for (int h = 0; h < hold; h++) begin
            start = h[0];
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_z"}, 32'(out_z), 32'(ez));
        end
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_busy"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int         sum;
        int         n;
        logic [2:0] ra;
        logic [2:0] rb;

        vecs[0] = '{n: 6, gap: 0, hold: 0,
                    va: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
                    vb: {3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd1}, z: 6'd41, ovf: 1'b0};
        vecs[1] = '{n: 3, gap: 0, hold: 0,
                    va: {3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7},
                    vb: {3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7}, z: 6'd19, ovf: 1'b1};
        vecs[2] = '{n: 1, gap: 0, hold: 0,
                    va: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2},
                    vb: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3}, z: 6'd6, ovf: 1'b0};
        vecs[3] = '{n: 4, gap: 3, hold: 5,
                    va: {3'd0, 3'd0, 3'd7, 3'd0, 3'd3, 3'd1},
                    vb: {3'd0, 3'd0, 3'd1, 3'd5, 3'd3, 3'd2}, z: 6'd18, ovf: 1'b0};

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            qa.delete(); qb.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                qa.push_back(vecs[v].va[i]);
                qb.push_back(vecs[v].vb[i]);
            end
            run_job(vecs[v].n, vecs[v].gap, vecs[v].hold, vecs[v].z, vecs[v].ovf,
                    $sformatf("vec%0d", v));
        end

        qa.delete(); qb.delete();
        run_job(0, 0, 2, 6'd0, 1'b0, "zero_len");

        // Abort mid-job: two pairs in, then reset.
        start = 1'b1; len = 4'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 3'd7; in_b = 3'd7;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_z", 32'(out_z), 32'd0);
        chk("abort_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        qa = '{3'd3}; qb = '{3'd3};
        run_job(1, 0, 0, 6'd9, 1'b0, "after_abort");

        // Start held high across two jobs: exactly one IDLE cycle between them.
        start = 1'b1; len = 4'd2; out_ready = 1'b1;
        step();
        for (int j = 0; j < 2; j++) begin
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1; in_a = 3'd1; in_b = 3'd1;
            step();
            step();
            in_valid = 1'b0;
            step();
            chk("b2b_out_valid", 32'(out_valid), 32'd1);
            chk("b2b_out_z", 32'(out_z), 32'd2);
            step();
            chk("b2b_idle", 32'(busy), 32'd0);
            if (j == 1) start = 1'b0;
            step();
        end
        chk("b2b_stopped", 32'(busy), 32'd0);

        // Random jobs against a plain-arithmetic dot-product model.
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 15);
            sum = 0;
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                ra = 3'($urandom);
                rb = 3'($urandom);
                qa.push_back(ra);
                qb.push_back(rb);
                sum += int'(ra) * int'(rb);
            end
            run_job(n, $urandom_range(0, 2), $urandom_range(0, 2),
                    6'(sum % 64), sum > 63, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
